pipeline_hazard_ctrl: RTL



---
 rtl/hazard_pkg.sv | 14 +
 rtl/sat_counter.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

  localparam int unsigned REG_W_DEF = 5;
  localparam int unsigned X0        = 0;
  localparam int unsigned CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, used for performance debug.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken-branch and
// data-memory wait hazards, with saturating stall/flush event counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W        = REG_W_DEF,
  parameter int unsigned FLUSH_LEN    = 1,
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             idex_hold,
  output logic             exmem_flush,
  output logic             exmem_hold,
  output logic             err_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WCNT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam int unsigned FCNT_W = $clog2(FLUSH_LEN + 1);

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              lu_c;
  logic              mem_wait_c;
  logic              wait_expired_c;
  logic              timeout_c;
  logic              flush_evt_c;

  assign lu_c = idex_memread && (idex_rd != REG_W'(X0)) &&
                ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
  assign mem_wait_c     = mem_req && !mem_ready;
  assign wait_expired_c = (wcnt_q == WCNT_W'(WAIT_TIMEOUT));
  assign flush_evt_c    = (state_q == RUN) && branch_taken;

  // State, wait/flush counters and sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      wcnt_q      <= '0;
      fcnt_q      <= '0;
      err_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      fcnt_q  <= fcnt_d;
      if (timeout_c) begin
        err_timeout <= 1'b1;
      end
    end
  end

  // Next-state: wait cycles count from the RUN cycle that first froze MEM
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    fcnt_d    = fcnt_q;
    timeout_c = 1'b0;
    unique case (state_q)
      RUN: begin
        if (branch_taken) begin
          if (FLUSH_LEN > 1) begin
            fcnt_d  = FCNT_W'(FLUSH_LEN - 1);
            state_d = FLUSH;
          end
        end else if (mem_wait_c) begin
          wcnt_d  = WCNT_W'(1);
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          wcnt_d  = '0;
          state_d = RUN;
        end else if (wait_expired_c) begin
          timeout_c = 1'b1;
          wcnt_d    = '0;
          state_d   = RUN;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      FLUSH: begin
        fcnt_d = fcnt_q - FCNT_W'(1);
        if (fcnt_q == FCNT_W'(1)) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Control outputs: zero-latency decode of state and current inputs
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    idex_hold   = 1'b0;
    exmem_flush = 1'b0;
    exmem_hold  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          exmem_flush = 1'b1;
        end else if (mem_wait_c) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_hold  = 1'b1;
          exmem_hold = 1'b1;
        end else if (lu_c) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready && !wait_expired_c) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_hold  = 1'b1;
          exmem_hold = 1'b1;
        end else if (lu_c) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
      end
      FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      default: begin
      end
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (~pc_write),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (flush_evt_c),
    .count (flush_cnt)
  );

endmodule
